// File: rtl/ser_pkg.sv
// Shared types and helpers for the bit serializer and its bit counter.
package ser_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} ser_state_t;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Bit position counter: clear, increment, terminal-count flag at WIDTH-1.
module ser_bit_counter
  import ser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // Saturates at LAST; wrapping only happens through an explicit clear.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !tc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with valid/ready input and framed, registered
// serial output (first/last markers), supporting back-to-back words.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] InData,
  input  logic             InValid,
  output logic             InReady,
  output logic             SerOut,
  output logic             SerValid,
  output logic             SerFirst,
  output logic             SerLast,
  output logic             Busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(WIDTH - 2);

  ser_state_t       state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CNT_W-1:0] bit_cnt;
  logic             tc, xfer, clr, inc;
  logic             first_n, last_n;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  ser_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk (Clock),
    .rst (Reset),
    .clr (clr),
    .inc (inc),
    .cnt (bit_cnt),
    .tc  (tc)
  );

  assign InReady = !Reset && ((state == IDLE) || ((state == SHIFT) && tc));
  assign xfer    = InValid && InReady;
  assign Busy    = (state == SHIFT);

  always_comb begin
    state_n = IDLE;
    shreg_n = '0;
    clr     = 1'b0;
    inc     = 1'b0;
    first_n = 1'b0;
    last_n  = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          state_n = SHIFT;
          shreg_n = InData;
          clr     = 1'b1;
          first_n = 1'b1;
        end
      end
      SHIFT: begin
        if (!tc) begin
          state_n = SHIFT;
          shreg_n = shift_once(shreg);
          inc     = 1'b1;
          last_n  = (bit_cnt == PRE_LAST);
        end else if (xfer) begin
          // Reload on the last bit so the next word follows with no gap.
          state_n = SHIFT;
          shreg_n = InData;
          clr     = 1'b1;
          first_n = 1'b1;
        end else begin
          clr = 1'b1;
        end
      end
      default: clr = 1'b1;
    endcase
  end

  // Serial outputs are registered from the next-state values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      shreg    <= '0;
      SerOut   <= 1'b0;
      SerValid <= 1'b0;
      SerFirst <= 1'b0;
      SerLast  <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      SerOut   <= (state_n == SHIFT) ? head_bit(shreg_n) : 1'b0;
      SerValid <= (state_n == SHIFT);
      SerFirst <= first_n;
      SerLast  <= last_n;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer: table vectors, framing sequences, random
// traffic against a queue-based model, and an MSB-first WIDTH=4 instance.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst, in_valid;
  logic [7:0] in_data;
  logic       in_ready, ser_out, ser_valid, ser_first, ser_last, busy;

  logic       rst2, in_valid2;
  logic [3:0] in_data2;
  logic       in_ready2, ser_out2, ser_valid2, ser_first2, ser_last2, busy2;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {bit b; bit f; bit l;} sbit_t;
  sbit_t mq[$];

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] data;
    logic [5:0] exp;  // {ready, out, valid, first, last, busy}
  } vec_t;
  vec_t tbl[13];

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut (
    .Clock(clk), .Reset(rst), .InData(in_data), .InValid(in_valid),
    .InReady(in_ready), .SerOut(ser_out), .SerValid(ser_valid),
    .SerFirst(ser_first), .SerLast(ser_last), .Busy(busy)
  );

  bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .Clock(clk), .Reset(rst2), .InData(in_data2), .InValid(in_valid2),
    .InReady(in_ready2), .SerOut(ser_out2), .SerValid(ser_valid2),
    .SerFirst(ser_first2), .SerLast(ser_last2), .Busy(busy2)
  );

  // One clock edge; the model consumes the bit just shown and captures a word
  // when the handshake completes, then the bench settles on the falling edge.
  task automatic step();
    bit acc;
    acc = in_valid && !rst && (mq.size() <= 1);
    @(posedge clk);
    if (rst) begin
      mq.delete();
    end else begin
      if (mq.size() > 0) void'(mq.pop_front());
      if (acc) begin
        for (int i = 0; i < 8; i++) mq.push_back('{in_data[i], i == 0, i == 7});
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [5:0] model_exp();
    logic rdy;
    rdy = !rst && (mq.size() <= 1);
    if (mq.size() > 0) return {rdy, mq[0].b, 1'b1, mq[0].f, mq[0].l, 1'b1};
    return {rdy, 5'b00000};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {in_ready, ser_out, ser_valid, ser_first, ser_last, busy};
  endfunction

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = dut_vec();
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got {rdy,out,vld,first,last,busy}=%b expected %b",
               name, $time, act, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_msb(input string name, input logic [3:0] exp);
    logic [3:0] act;
    act = {ser_out2, ser_valid2, ser_first2, ser_last2};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got {out,vld,first,last}=%b expected %b",
               name, $time, act, exp);
    end
  endtask

  initial begin
    logic [15:0] cap;
    int          run;

    tbl[0]  = '{1'b1, 1'b0, 8'h00, 6'b000000};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 6'b100000};
    tbl[2]  = '{1'b0, 1'b1, 8'hA5, 6'b011101};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 6'b001001};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 6'b011001};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 6'b001001};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 6'b001001};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 6'b011001};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 6'b001001};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 6'b111011};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 6'b100000};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 6'b100000};
    tbl[12] = '{1'b1, 1'b1, 8'h5A, 6'b000000};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    rst2 = 1'b1; in_valid2 = 1'b0; in_data2 = 4'h0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst; in_valid = tbl[i].vld; in_data = tbl[i].data;
      step();
      check($sformatf("table[%0d]", i), tbl[i].exp);
    end
    rst = 1'b0; in_valid = 1'b0;
    step();
    check("idle_after_table", model_exp());

    // Back-to-back: 0F then F0 offered while InValid stays high.
    in_valid = 1'b1; in_data = 8'h0F; cap = '0; run = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      check("b2b", model_exp());
      if (ser_valid) begin cap = {cap[14:0], ser_out}; run++; end
      if (k == 0) in_data = 8'hF0;
      if (k == 8) in_valid = 1'b0;
    end
    check_val("b2b_bits", int'(cap), 16'hF00F);
    check_val("b2b_valid_cycles", run, 16);

    // Backpressure: 01 waits until the last bit of FF.
    in_valid = 1'b1; in_data = 8'hFF; cap = '0; run = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      check("backpressure", model_exp());
      if (ser_valid) begin cap = {cap[14:0], ser_out}; run++; end
      if (k == 0) in_data = 8'h01;
      if (k == 8) in_valid = 1'b0;
    end
    check_val("bp_bits", int'(cap), 16'hFF80);
    check_val("bp_valid_cycles", run, 16);

    // Reset after three bits of 3C; the remainder must never appear.
    in_valid = 1'b1; in_data = 8'h3C;
    step(); check("rst_mid_bit0", model_exp());
    in_valid = 1'b0;
    step(); check("rst_mid_bit1", model_exp());
    step(); check("rst_mid_bit2", model_exp());
    rst = 1'b1; in_valid = 1'b1;
    step(); check("rst_mid_during", 6'b000000);
    rst = 1'b0; in_valid = 1'b0;
    #1 check("rst_mid_release", 6'b100000);
    for (int k = 0; k < 6; k++) begin
      step();
      check("rst_mid_idle", 6'b100000);
    end

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      rst      = ($urandom_range(0, 59) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = 8'($urandom);
      step();
      check("random", model_exp());
    end
    rst = 1'b0; in_valid = 1'b0;

    // MSB-first, WIDTH=4.
    rst2 = 1'b0; in_valid2 = 1'b1; in_data2 = 4'b1000;
    step(); check_msb("msb_bit0", 4'b1110);
    in_valid2 = 1'b0;
    step(); check_msb("msb_bit1", 4'b0100);
    step(); check_msb("msb_bit2", 4'b0100);
    step(); check_msb("msb_bit3", 4'b0101);
    step(); check_msb("msb_idle", 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial stage upstream of the serial sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on SerOut, with SerValid qualifying each bit.
- The downstream detector advances only on cycles where SerValid=1.
- Supports back-to-back words with no idle gap, plus first-bit and last-bit markers for framing.

Parameters:
- WIDTH, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 0: 0 emits bit 0 first; 1 emits bit WIDTH-1 first.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- InData  in  WIDTH  parallel word; sampled on handshake
- InValid  in  1  InData holds a word
- InReady  out  1  block can accept a word this cycle
- SerOut  out  1  serial data bit
- SerValid  out  1  SerOut is a valid bit this cycle
- SerFirst  out  1  high with the first bit of each word
- SerLast  out  1  high with the last bit of each word
- Busy  out  1  a word is being shifted (state SHIFT)

Behaviour:
- One clock; reset is synchronous and active-high. All state changes on the rising edge of Clock.
- Reset (Reset=1 at an edge): state=IDLE, shift register=0, BitCnt=0.
  - Registered outputs clear: SerOut=0, SerValid=0, SerFirst=0, SerLast=0, Busy=0.
  - InReady is forced to 0 while Reset=1.
- Handshake: a word transfers on an edge where InValid=1 and InReady=1. InData is sampled only at that edge.
- Handshake must not wait: InValid must not depend combinationally on InReady. InReady may depend on state and BitCnt only.
- FSM states: IDLE, SHIFT.
- IDLE:
  - InReady=1; SerValid=0; SerOut=0; SerFirst=0; SerLast=0.
  - On transfer: load the shift register, set BitCnt=0, go to SHIFT.
  - Latency: the first bit appears with SerValid=1 in the cycle after the transfer edge.
- SHIFT:
  - SerValid=1 every cycle.
  - SerOut = shreg[0] when MSB_FIRST=0; SerOut = shreg[WIDTH-1] when MSB_FIRST=1.
  - SerFirst=1 when BitCnt=0; SerLast=1 when BitCnt=WIDTH-1.
  - Each edge shifts the register one position (right for LSB-first, left for MSB-first) and increments BitCnt.
- Last bit (BitCnt=WIDTH-1):
  - InReady=1.
  - If a transfer occurs: reload, BitCnt=0, stay in SHIFT. The next word's first bit follows with no gap.
  - Otherwise: return to IDLE.
- InReady=0 in SHIFT for BitCnt < WIDTH-1. InValid held high during that time causes no capture and no data loss.
- Output timing: SerOut, SerValid, SerFirst and SerLast are registered (flop outputs, no combinational path from InData/InValid). InReady is combinational from state/BitCnt.
- Counter width: BitCnt is $clog2(WIDTH) bits. It never exceeds WIDTH-1; wrap is by explicit reload, never by natural overflow.
- Reset mid-word: the remaining bits are discarded. SerValid=0 in the first cycle after reset and no partial word resumes.
- Reset with InValid=1: no capture at that edge.
- Illegal state encoding: recover to IDLE on the next edge with outputs cleared.
- Words are never reordered, dropped once accepted, or duplicated.

Decomposition:
- Package ser_pkg: typedef enum logic {IDLE, SHIFT} ser_state_t; localparam default WIDTH; helper function for bit-count width.
- One sub-module is natural: ser_bit_counter (load/increment/terminal-count flag at WIDTH-1), reusable by a future deserializer.
- Shift register and FSM stay in the top module.

Test Plan:
- Basic LSB-first, WIDTH=8:
  - Stimulus: reset, then offer 8'hA5 once.
  - Response: InReady=1 at transfer; next 8 cycles SerValid=1, SerOut=1,0,1,0,0,1,0,1.
  - SerFirst on cycle 1 only; SerLast on cycle 8 only; then SerValid=0, Busy=0.
- Back-to-back:
  - Stimulus: InValid held high with 8'h0F, then 8'hF0 presented at the last-bit cycle.
  - Response: 16 consecutive SerValid=1 cycles, bits 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1; SerLast at cycles 8 and 16, SerFirst at cycles 1 and 9.
- Backpressure:
  - Stimulus: offer 8'h01 while shifting 8'hFF.
  - Response: InReady=0 for cycles 1-7 of 8'hFF; 8'h01 is accepted only at cycle 8; 8'hFF emitted intact, followed immediately by 1,0,0,0,0,0,0,0.
- Reset mid-word:
  - Stimulus: assert Reset for one edge after 3 bits of 8'h3C.
  - Response: all outputs 0 next cycle; state IDLE; InReady=0 during Reset, 1 after; the remaining 5 bits never appear.
- MSB_FIRST=1, WIDTH=4:
  - Stimulus: offer 4'b1000.
  - Response: SerOut=1,0,0,0 with SerFirst on the 1 and SerLast on the final 0.
- Detector integration:
  - Stimulus: feed words producing stream 0,1,1,1,0 into the downstream detector, clock-enabled by SerValid.
  - Response: detector output reaches 1 after the second 0, identical to the ungapped stream.
